zigzag_block_sequencer: RTL and testbench
=========================================

// Module: zigzag_block_sequencer
// PURPOSE
//  Sequences the 64x8 zigzag databuffer for one 8x8 block at a time. Accepts 64 raster-order
//  samples on a valid/ready stream, writes them into the buffer, and pulses the zigzag enable.
//  Captures the 512-bit zigzag result and streams it out one coefficient per beat, flagging the last.
//  Sits between the quantiser output and the run-length/entropy encoder.
// PARAMETERS
//  DATA_WIDTH   8  bits per coefficient
//  ZZ_LATENCY   1  cycles from zz_enable sampled high to zz_data valid (legal range 1..15)
// PORTS
//  clock        in   1                clock, rising edge
//  reset_n      in   1                asynchronous, active-low reset
//  abort        in   1                synchronous clear to FILL; block_count is unchanged
//  in_valid     in   1                upstream sample valid
//  in_ready     out  1                high only in FILL
//  in_data      in   DATA_WIDTH       raster-order sample
//  buf_wr_en    out  1                buffer single-address write strobe
//  buf_wr_addr  out  8                buffer write address, 0..63
//  buf_wr_data  out  DATA_WIDTH       buffer write data
//  zz_enable    out  1                one-cycle pulse that launches the zigzag reorder
//  zz_data      in   64*DATA_WIDTH    zigzag result; element k = zz_data[64*DW-1-k*DW -: DW]
//  out_valid    out  1                coefficient valid
//  out_ready    in   1                downstream accept
//  out_data     out  DATA_WIDTH       zigzag-order coefficient
//  out_index    out  6                zigzag index of out_data
//  out_last     out  1                high with out_index==63
//  busy         out  1                high in any state other than FILL
//  block_count  out  16               completed blocks, wraps at 65535->0
// BEHAVIOUR
//  - Reset: FILL state; fill_cnt=0; all outputs 0 except in_ready=1.
//  - FILL: in_ready=1. A beat transfers when in_valid&in_ready.
//    - Each transfer drives buf_wr_en=1, buf_wr_addr=fill_cnt, buf_wr_data=in_data, combinationally
//      in the same cycle. fill_cnt then increments.
//    - The transfer with fill_cnt==63 moves the FSM to KICK; fill_cnt returns to 0.
//  - KICK (1 cycle): zz_enable=1, in_ready=0, buf_wr_en=0. Next state is WAIT; lat_cnt loads ZZ_LATENCY-1.
//  - WAIT: lat_cnt decrements each cycle. In the cycle lat_cnt==0, all of zz_data is captured into
//    the internal 64-entry register. Next state is DRAIN; drain_idx=0.
//  - DRAIN: out_valid=1, out_data=cap[drain_idx], out_index=drain_idx, out_last=(drain_idx==63).
//    - Outputs are registered and held stable while out_valid&~out_ready.
//    - On out_valid&out_ready, drain_idx increments.
//    - The beat with drain_idx==63 returns the FSM to FILL, increments block_count, and clears out_valid.
//  - Back-to-back blocks: a new block's first input can transfer in the cycle after out_last is accepted.
//    The minimum block period is 64+1+ZZ_LATENCY+64 cycles.
//  - in_valid while not in FILL: ignored. in_ready=0 and no buffer write occurs.
//  - abort: highest priority. Next cycle the state is FILL, fill_cnt=0, out_valid=0, and any partial
//    block is discarded. zz_enable is never issued for a partial block.
//  - Asynchronous reset mid-operation: immediate return to reset values. A partially sent block is
//    not completed.
//  - buf_wr_addr[7:6] is always 0.
// TESTING
//  1. Stream in_data=0..63 continuously with out_ready=1. Required: zz_enable pulses exactly once.
//     Outputs are out_data=0,1,8,16,9,2,... (standard JPEG zigzag). out_last at index 63.
//     block_count=1.
//  2. Toggle in_valid randomly during FILL. Required: exactly 64 buf_wr_en pulses, at addresses
//     0..63 in order, with no gaps in addr.
//  3. Hold out_ready=0 for 10 cycles at drain_idx=5. Required: out_data/out_index stay at
//     cap[5]/5. Resume: index 6 follows.
//  4. Assert abort at fill_cnt=40. Required: in_ready=1 next cycle. The next 64 inputs form a
//     complete block. block_count is unchanged until that block drains.
//  5. ZZ_LATENCY=3, two back-to-back blocks. Required: out_valid rises 4 cycles after zz_enable.
//     in_ready=0 throughout KICK/WAIT/DRAIN. block_count=2.
//  6. Assert reset_n low during DRAIN at drain_idx=30. Required: out_valid=0 and in_ready=1
//     asynchronously. block_count=0.

Source files
------------

// File: rtl/zigzag_block_sequencer.sv
// Zigzag block sequencer: fills the 64-entry zigzag buffer from a raster-order
// sample stream, launches the reorder, captures the 64 reordered coefficients
// and streams them out one per beat with index and last flag.
module zigzag_block_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ZZ_LATENCY = 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       abort,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       buf_wr_en,
  output logic [7:0]                 buf_wr_addr,
  output logic [DATA_WIDTH-1:0]      buf_wr_data,
  output logic                       zz_enable,
  input  logic [64*DATA_WIDTH-1:0]   zz_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [5:0]                 out_index,
  output logic                       out_last,
  output logic                       busy,
  output logic [15:0]                block_count
);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_KICK  = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // The wait counter is preloaded so that the capture happens in the cycle it reaches zero.
  localparam logic [3:0] LAT_INIT = 4'(ZZ_LATENCY - 1);

  state_t                state_q, state_d;
  logic [5:0]            fill_cnt_q, fill_cnt_d;
  logic [3:0]            lat_cnt_q, lat_cnt_d;
  logic [5:0]            drain_idx_q, drain_idx_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic [15:0]           block_count_q, block_count_d;
  logic [DATA_WIDTH-1:0] cap_q [64];
  logic [DATA_WIDTH-1:0] cap_d [64];

  logic                  in_fire;
  logic                  out_fire;
  logic                  capture;
  logic [5:0]            next_idx;

  // Next-state, datapath updates and combinational handshake outputs.
  always_comb begin
    state_d       = state_q;
    fill_cnt_d    = fill_cnt_q;
    lat_cnt_d     = lat_cnt_q;
    drain_idx_d   = drain_idx_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_last_d    = out_last_q;
    block_count_d = block_count_q;
    cap_d         = cap_q;
    capture       = 1'b0;
    next_idx      = drain_idx_q + 6'd1;

    in_ready    = (state_q == S_FILL);
    busy        = (state_q != S_FILL);
    zz_enable   = (state_q == S_KICK);
    in_fire     = in_valid & in_ready;
    out_fire    = out_valid_q & out_ready;
    buf_wr_en   = in_fire & ~abort;
    buf_wr_addr = {2'b00, fill_cnt_q};
    buf_wr_data = in_data;

    case (state_q)
      S_FILL: begin
        if (in_fire) begin
          fill_cnt_d = fill_cnt_q + 6'd1;
          if (fill_cnt_q == 6'd63) begin
            state_d = S_KICK;
          end
        end
      end
      S_KICK: begin
        state_d   = S_WAIT;
        lat_cnt_d = LAT_INIT;
      end
      S_WAIT: begin
        if (lat_cnt_q == 4'd0) begin
          capture     = 1'b1;
          state_d     = S_DRAIN;
          drain_idx_d = 6'd0;
          out_valid_d = 1'b1;
          out_data_d  = zz_data[64*DATA_WIDTH-1 -: DATA_WIDTH];
          out_last_d  = 1'b0;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      S_DRAIN: begin
        if (out_fire) begin
          if (drain_idx_q == 6'd63) begin
            state_d       = S_FILL;
            drain_idx_d   = 6'd0;
            out_valid_d   = 1'b0;
            out_data_d    = '0;
            out_last_d    = 1'b0;
            block_count_d = block_count_q + 16'd1;
          end else begin
            drain_idx_d = next_idx;
            out_data_d  = cap_q[next_idx];
            out_last_d  = (next_idx == 6'd63);
          end
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase

    if (abort) begin
      state_d       = S_FILL;
      fill_cnt_d    = 6'd0;
      lat_cnt_d     = 4'd0;
      drain_idx_d   = 6'd0;
      out_valid_d   = 1'b0;
      out_data_d    = '0;
      out_last_d    = 1'b0;
      block_count_d = block_count_q;
      capture       = 1'b0;
    end

    if (capture) begin
      for (int k = 0; k < 64; k++) begin
        cap_d[k] = zz_data[64*DATA_WIDTH-1-k*DATA_WIDTH -: DATA_WIDTH];
      end
    end
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_FILL;
      fill_cnt_q    <= 6'd0;
      lat_cnt_q     <= 4'd0;
      drain_idx_q   <= 6'd0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      block_count_q <= 16'd0;
      for (int k = 0; k < 64; k++) begin
        cap_q[k] <= '0;
      end
    end else begin
      state_q       <= state_d;
      fill_cnt_q    <= fill_cnt_d;
      lat_cnt_q     <= lat_cnt_d;
      drain_idx_q   <= drain_idx_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_last_q    <= out_last_d;
      block_count_q <= block_count_d;
      cap_q         <= cap_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_index   = drain_idx_q;
  assign out_last    = out_last_q;
  assign block_count = block_count_q;

endmodule

// File: tb/tb_zigzag_block_sequencer.sv
// Testbench for zigzag_block_sequencer: models the zigzag buffer with a
// configurable latency and checks the coefficient stream against a scoreboard.
module tb_zigzag_block_sequencer;

  localparam int DW      = 8;
  localparam int LAT     = 3;
  localparam int TIMEOUT = 2000;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              abort;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_data;
  logic              buf_wr_en;
  logic [7:0]        buf_wr_addr;
  logic [DW-1:0]     buf_wr_data;
  logic              zz_enable;
  logic [64*DW-1:0]  zz_data;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [5:0]        out_index;
  logic              out_last;
  logic              busy;
  logic [15:0]       block_count;

  typedef struct {
    logic [7:0] data;
    logic [5:0] index;
  } expect_t;

  int zzOrder[64] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  expect_t     sbQueue[$];
  expect_t     popped;
  logic [7:0]  blockSamples[64];
  logic [7:0]  bufMem[64];
  logic [LAT-1:0] zzPipe;

  int testsRun = 0;
  int testsFailed = 0;
  int cycleCnt = 0;
  int zzPulses = 0;
  int wrCount = 0;
  int kickCycle = 0;
  int lastAcceptCycle = -10;
  int firstWrCycle = -10;
  int expAddr = 0;
  bit inTail = 1'b0;
  logic prevValid = 1'b0;

  int wr0;
  int z0;
  int lastAcc0;

  zigzag_block_sequencer #(.DATA_WIDTH(DW), .ZZ_LATENCY(LAT)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .abort       (abort),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .buf_wr_en   (buf_wr_en),
    .buf_wr_addr (buf_wr_addr),
    .buf_wr_data (buf_wr_data),
    .zz_enable   (zz_enable),
    .zz_data     (zz_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_index   (out_index),
    .out_last    (out_last),
    .busy        (busy),
    .block_count (block_count)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Cycle counter used for latency and back-to-back timing checks.
  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  // Zigzag buffer model: raster writes, result valid LAT cycles after the enable.
  always @(posedge clock) begin
    if (buf_wr_en) bufMem[buf_wr_addr[5:0]] <= buf_wr_data;
  end

  // Enable delay line of the buffer model.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) zzPipe <= '0;
    else          zzPipe <= {zzPipe[LAT-2:0], zz_enable};
  end

  // Reordered result presented only in its valid cycle, filler otherwise.
  always_comb begin
    for (int k = 0; k < 64; k++) begin
      zz_data[(63-k)*8 +: 8] = zzPipe[LAT-1] ? bufMem[zzOrder[k]] : 8'hEE;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Output monitor: write addresses, scoreboard pops, latency and busy checks.
  always @(negedge clock) begin
    if (!reset_n) begin
      expAddr   = 0;
      inTail    = 1'b0;
      prevValid = 1'b0;
    end else begin
      if (buf_wr_en) begin
        checkOutput("wr_addr", 32'(buf_wr_addr), 32'(expAddr));
        if (expAddr == 0) firstWrCycle = cycleCnt;
        expAddr = (expAddr + 1) % 64;
        wrCount++;
      end
      if (zz_enable) begin
        zzPulses++;
        kickCycle = cycleCnt;
        inTail = 1'b1;
      end
      if (out_valid && !prevValid) begin
        checkOutput("kick_to_valid", 32'(cycleCnt - kickCycle), 32'(LAT + 1));
      end
      prevValid = out_valid;
      if (inTail) begin
        checkOutput("in_ready_busy_tail", 32'({in_ready, busy}), 32'(2'b01));
      end
      if (out_valid && out_ready) begin
        if (sbQueue.size() == 0) begin
          checkOutput("sb_unexpected_output", 32'(1), 32'(0));
        end else begin
          popped = sbQueue.pop_front();
          checkOutput("out_data", 32'(out_data), 32'(popped.data));
          checkOutput("out_index", 32'(out_index), 32'(popped.index));
          checkOutput("out_last", 32'(out_last), 32'(popped.index == 6'd63));
        end
        if (out_last) begin
          lastAcceptCycle = cycleCnt;
          inTail = 1'b0;
        end
      end
      if (abort) begin
        expAddr = 0;
        inTail  = 1'b0;
      end
    end
  end

  task automatic sendBeat(input logic [7:0] v, input int maxGap);
    bit ok;
    repeat ($urandom_range(0, maxGap)) begin
      @(posedge clock); #1;
    end
    in_valid = 1'b1;
    in_data  = v;
    ok = 1'b0;
    for (int g = 0; g < TIMEOUT; g++) begin
      @(negedge clock);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("in_ready_timeout", 32'(0), 32'(1));
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  // Drives numBeats samples; a full block also queues its zigzag-order expectations.
  task automatic applyStimulus(input int pattern, input int maxGap, input int numBeats);
    for (int i = 0; i < 64; i++) begin
      blockSamples[i] = (pattern == 0) ? 8'(i) : 8'($urandom_range(0, 200));
    end
    for (int i = 0; i < numBeats; i++) begin
      sendBeat(blockSamples[i], maxGap);
    end
    if (numBeats == 64) begin
      for (int k = 0; k < 64; k++) begin
        sbQueue.push_back('{data: blockSamples[zzOrder[k]], index: 6'(k)});
      end
    end
  endtask

  task automatic waitBlockCount(input logic [15:0] target);
    for (int g = 0; g < TIMEOUT; g++) begin
      @(negedge clock);
      if (block_count == target) break;
    end
    checkOutput("block_count", 32'(block_count), 32'(target));
    @(posedge clock); #1;
  endtask

  task automatic waitOutValid();
    bit ok;
    ok = 1'b0;
    for (int g = 0; g < TIMEOUT; g++) begin
      @(negedge clock);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("out_valid_timeout", 32'(0), 32'(1));
    @(posedge clock); #1;
  endtask

  // Guard against a hung simulation.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time %0t reached without finishing, limit 1000000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    reset_n   = 1'b0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_in_ready", 32'(in_ready), 32'(1));
    checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    checkOutput("rst_zz_enable", 32'(zz_enable), 32'(0));
    checkOutput("rst_buf_wr_en", 32'(buf_wr_en), 32'(0));
    checkOutput("rst_block_count", 32'(block_count), 32'(0));
    checkOutput("rst_out_index", 32'(out_index), 32'(0));
    checkOutput("rst_out_last", 32'(out_last), 32'(0));
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    $display("[TB] test 1: raster ramp, continuous stream");
    out_ready = 1'b1;
    wr0 = wrCount;
    z0  = zzPulses;
    applyStimulus(0, 0, 64);
    waitBlockCount(16'd1);
    checkOutput("t1_zz_pulses", 32'(zzPulses - z0), 32'(1));
    checkOutput("t1_writes", 32'(wrCount - wr0), 32'(64));
    checkOutput("t1_sb_empty", 32'(sbQueue.size()), 32'(0));

    $display("[TB] test 2: random in_valid gaps");
    wr0 = wrCount;
    applyStimulus(1, 3, 64);
    waitBlockCount(16'd2);
    checkOutput("t2_writes", 32'(wrCount - wr0), 32'(64));

    $display("[TB] test 3: downstream stall at index 5");
    out_ready = 1'b0;
    applyStimulus(1, 0, 64);
    waitOutValid();
    out_ready = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    out_ready = 1'b0;
    repeat (10) begin
      @(negedge clock);
      checkOutput("t3_stall_valid", 32'(out_valid), 32'(1));
      checkOutput("t3_stall_index", 32'(out_index), 32'(5));
      checkOutput("t3_stall_data", 32'(out_data), 32'(blockSamples[zzOrder[5]]));
    end
    @(posedge clock); #1;
    out_ready = 1'b1;
    waitBlockCount(16'd3);

    $display("[TB] test 4: abort at fill count 40");
    z0 = zzPulses;
    applyStimulus(1, 0, 40);
    checkOutput("t4_count_partial", 32'(block_count), 32'(3));
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    @(negedge clock);
    checkOutput("t4_in_ready_after_abort", 32'(in_ready), 32'(1));
    checkOutput("t4_count_after_abort", 32'(block_count), 32'(3));
    @(posedge clock); #1;
    wr0 = wrCount;
    applyStimulus(1, 1, 64);
    @(negedge clock);
    checkOutput("t4_count_before_drain", 32'(block_count), 32'(3));
    @(posedge clock); #1;
    waitBlockCount(16'd4);
    checkOutput("t4_writes", 32'(wrCount - wr0), 32'(64));
    checkOutput("t4_zz_pulses", 32'(zzPulses - z0), 32'(1));

    $display("[TB] test 4b: abort during drain");
    out_ready = 1'b0;
    applyStimulus(1, 0, 64);
    waitOutValid();
    out_ready = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    out_ready = 1'b0;
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    @(negedge clock);
    checkOutput("t4b_out_valid", 32'(out_valid), 32'(0));
    checkOutput("t4b_in_ready", 32'(in_ready), 32'(1));
    checkOutput("t4b_count", 32'(block_count), 32'(4));
    sbQueue.delete();
    @(posedge clock); #1;
    out_ready = 1'b1;

    $display("[TB] test 5: back-to-back blocks, latency %0d", LAT);
    z0 = zzPulses;
    applyStimulus(1, 0, 64);
    lastAcc0 = lastAcceptCycle;
    applyStimulus(1, 0, 64);
    checkOutput("t5_first_block_drained", 32'(lastAcceptCycle != lastAcc0), 32'(1));
    checkOutput("t5_back_to_back_gap", 32'(firstWrCycle - lastAcceptCycle), 32'(1));
    waitBlockCount(16'd6);
    checkOutput("t5_zz_pulses", 32'(zzPulses - z0), 32'(2));

    $display("[TB] test 6: asynchronous reset at index 30");
    out_ready = 1'b0;
    applyStimulus(1, 0, 64);
    waitOutValid();
    out_ready = 1'b1;
    repeat (30) @(posedge clock);
    #1;
    out_ready = 1'b0;
    @(negedge clock);
    checkOutput("t6_pre_index", 32'(out_index), 32'(30));
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    checkOutput("t6_out_valid", 32'(out_valid), 32'(0));
    checkOutput("t6_in_ready", 32'(in_ready), 32'(1));
    checkOutput("t6_busy", 32'(busy), 32'(0));
    checkOutput("t6_block_count", 32'(block_count), 32'(0));
    sbQueue.delete();
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b1;
    applyStimulus(0, 0, 64);
    waitBlockCount(16'd1);
    checkOutput("t6_sb_empty", 32'(sbQueue.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
